// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment scanner:
// scan states, blanking constants and the active-low segment patterns.
package display_scan_ctrl_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Segment order {a,b,c,d,e,f,g}, low = lit
  localparam logic [6:0] SEG_D0 = 7'b0000001;
  localparam logic [6:0] SEG_D1 = 7'b1001111;
  localparam logic [6:0] SEG_D2 = 7'b0010010;
  localparam logic [6:0] SEG_D3 = 7'b0000110;
  localparam logic [6:0] SEG_D4 = 7'b1001100;
  localparam logic [6:0] SEG_D5 = 7'b0100100;
  localparam logic [6:0] SEG_D6 = 7'b0100000;
  localparam logic [6:0] SEG_D7 = 7'b0001111;
  localparam logic [6:0] SEG_D8 = 7'b0000000;
  localparam logic [6:0] SEG_D9 = 7'b0000100;

  function automatic logic has_bad_nibble(input logic [15:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) ||
           (v[11:8] > 4'd9) || (v[15:12] > 4'd9);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_dec.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes go dark.
module DecodificadorBCD
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_D0;
      4'd1:    seg = SEG_D1;
      4'd2:    seg = SEG_D2;
      4'd3:    seg = SEG_D3;
      4'd4:    seg = SEG_D4;
      4'd5:    seg = SEG_D5;
      4'd6:    seg = SEG_D6;
      4'd7:    seg = SEG_D7;
      4'd8:    seg = SEG_D8;
      4'd9:    seg = SEG_D9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment scan controller with double-buffered loads that
// commit only at frame boundaries, leading-zero blanking and a BCD error flag.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 4,
  parameter int LZ_BLANK     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        bcd_err
);

  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_e      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      display_q, display_d;
  logic [15:0]      pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  logic             bcd_err_q, bcd_err_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic       load_fire;
  logic       boundary;
  logic [3:0] dec_bcd;
  logic       lead_zero;
  logic [6:0] dec_seg;

  assign load_fire = load_valid && !pending_valid_q;

  // Next-state: dwell counting, digit rotation, load buffering
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    display_d       = display_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    bcd_err_d       = bcd_err_q;
    boundary        = 1'b0;

    case (state_q)
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == BLANK_LAST) begin
          state_d  = ST_SHOW;
          cnt_d    = '0;
          idx_d    = idx_q + 2'd1;
          boundary = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Commit uses the pending value held before this edge, so a load
    // accepted on the boundary edge itself waits a full frame.
    if (boundary && pending_valid_q) begin
      display_d       = pending_q;
      pending_valid_d = 1'b0;
      bcd_err_d       = has_bad_nibble(pending_q);
    end

    if (load_fire) begin
      pending_d       = load_data;
      pending_valid_d = 1'b1;
    end
  end

  always_comb begin
    dec_bcd   = display_d[3:0];
    lead_zero = 1'b0;
    case (idx_d)
      2'd1: begin
        dec_bcd   = display_d[7:4];
        lead_zero = (display_d[15:4] == 12'h000);
      end
      2'd2: begin
        dec_bcd   = display_d[11:8];
        lead_zero = (display_d[15:8] == 8'h00);
      end
      2'd3: begin
        dec_bcd   = display_d[15:12];
        lead_zero = (display_d[15:12] == 4'h0);
      end
      default: begin
        dec_bcd   = display_d[3:0];
        lead_zero = 1'b0;
      end
    endcase
  end

  DecodificadorBCD u_dec (
    .bcd (dec_bcd),
    .seg (dec_seg)
  );

  // Outputs follow the next state so seg/an and state change on one edge
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    if ((state_d == ST_SHOW) && !((LZ_BLANK != 0) && lead_zero)) begin
      seg_d = dec_seg;
      an_d  = ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_BLANK;
      idx_q           <= 2'd3;
      cnt_q           <= '0;
      display_q       <= 16'h0000;
      pending_valid_q <= 1'b0;
      bcd_err_q       <= 1'b0;
      seg_q           <= SEG_OFF;
      an_q            <= AN_OFF;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      display_q       <= display_d;
      pending_valid_q <= pending_valid_d;
      bcd_err_q       <= bcd_err_d;
      seg_q           <= seg_d;
      an_q            <= an_d;
    end
  end

  always_ff @(posedge clk) begin
    pending_q <= pending_d;
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign load_ready = !pending_valid_q;
  assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with PRESCALE=4, BLANK_CYCLES=1,
// so one frame is 20 cycles; positions below count cycles from a frame boundary.
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        bcd_err;

  int n_checks;
  int n_errors;

  display_scan_ctrl #(
    .PRESCALE     (4),
    .BLANK_CYCLES (1),
    .LZ_BLANK     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .seg        (seg),
    .an         (an),
    .bcd_err    (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts at position 0 of a frame, ends at position 0 of the next one.
  // Slot s expectations sit in an_exp[4s+:4] and seg_exp[7s+:7].
  task automatic check_frame(input string tag, input logic [15:0] an_exp,
                             input logic [27:0] seg_exp);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("%s_s%0d_an_first", tag, s), 32'(an), 32'(an_exp[4*s +: 4]));
      chk($sformatf("%s_s%0d_seg_first", tag, s), 32'(seg), 32'(seg_exp[7*s +: 7]));
      step(3);
      chk($sformatf("%s_s%0d_an_last", tag, s), 32'(an), 32'(an_exp[4*s +: 4]));
      chk($sformatf("%s_s%0d_seg_last", tag, s), 32'(seg), 32'(seg_exp[7*s +: 7]));
      step(1);
      chk($sformatf("%s_s%0d_an_blank", tag, s), 32'(an), 32'(4'b1111));
      chk($sformatf("%s_s%0d_seg_blank", tag, s), 32'(seg), 32'(7'b1111111));
      step(1);
    end
  endtask

  task automatic load_one(input logic [15:0] v);
    load_valid = 1'b1;
    load_data  = v;
    step(1);
    load_valid = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;

    // Reset held for three cycles
    step(3);
    chk("rst_seg", 32'(seg), 32'(7'b1111111));
    chk("rst_an", 32'(an), 32'(4'b1111));
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_err", 32'(bcd_err), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_an", 32'(an), 32'(4'b1110));
    chk("post_rst_seg", 32'(seg), 32'(7'b0000001));
    check_frame("zero", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001});

    // Load 1234 at position 0, shown from the next boundary
    load_one(16'h1234);
    chk("l1234_ready_low", 32'(load_ready), 32'd0);
    chk("l1234_not_yet", 32'(seg), 32'(7'b0000001));
    step(19);
    chk("l1234_ready_back", 32'(load_ready), 32'd1);
    check_frame("f1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});
    chk("f1234_period", 32'(seg), 32'(7'b1001100));

    // Load accepted on the boundary edge waits one more frame
    step(19);
    load_one(16'h0050);
    chk("bnd_old_seg", 32'(seg), 32'(7'b1001100));
    chk("bnd_ready_low", 32'(load_ready), 32'd0);
    step(20);
    check_frame("f0050", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001});

    // Back-to-back: 2222 held valid while 1111 is pending
    load_valid = 1'b1;
    load_data  = 16'h1111;
    step(1);
    load_data  = 16'h2222;
    step(1);
    chk("b2b_ready_p2", 32'(load_ready), 32'd0);
    step(17);
    chk("b2b_ready_p19", 32'(load_ready), 32'd0);
    step(1);
    chk("b2b_ready_bnd", 32'(load_ready), 32'd1);
    chk("b2b_seg_1111", 32'(seg), 32'(7'b1001111));
    step(1);
    load_valid = 1'b0;
    chk("b2b_ready_2222", 32'(load_ready), 32'd0);
    step(19);
    check_frame("f2222", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010});

    // Invalid nibble raises bcd_err at commit; a clean value clears it
    load_one(16'h00A1);
    chk("bad_err_before", 32'(bcd_err), 32'd0);
    step(19);
    chk("bad_err_set", 32'(bcd_err), 32'd1);
    check_frame("f00a1", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1001111});
    load_one(16'h0001);
    chk("bad_err_held", 32'(bcd_err), 32'd1);
    step(19);
    chk("bad_err_clr", 32'(bcd_err), 32'd0);
    chk("f0001_an", 32'(an), 32'(4'b1110));
    chk("f0001_seg", 32'(seg), 32'(7'b1001111));

    // Reset in the digit2 slot with 9999 pending
    load_one(16'h9999);
    chk("mid_pending", 32'(load_ready), 32'd0);
    step(10);
    rst_n = 1'b0;
    step(2);
    chk("mid_rst_seg", 32'(seg), 32'(7'b1111111));
    chk("mid_rst_an", 32'(an), 32'(4'b1111));
    chk("mid_rst_ready", 32'(load_ready), 32'd1);
    chk("mid_rst_err", 32'(bcd_err), 32'd0);
    rst_n = 1'b1;
    step(1);
    check_frame("mid_f0", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001});
    check_frame("mid_f1", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
